// File: rtl/bpmc_pkg.sv
// Shared definitions for the bipolar pulse-timing sequencer.
// Contents:
//   bpmc_state_t  - sequencer FSM state encoding (also driven on state_dbg)
//   BPMC_CNT_W    - default width of the delay/width/period fields
//   BPMC_BURST_W  - default width of the burst count field
package bpmc_pkg;

  localparam int BPMC_CNT_W   = 16;
  localparam int BPMC_BURST_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DELAY = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_FIN   = 3'd4
  } bpmc_state_t;

endpackage

// File: rtl/bpmc_down_counter.sv
// Loadable down-counter with terminal-count flag.
// Ports:
//   clk, rst    - rising-edge clock, synchronous active-high reset
//   load        - load load_value this cycle (takes priority over counting)
//   load_value  - value loaded when load is high
//   tc          - high while the count is zero
// The count holds at zero instead of wrapping, so tc stays high until the
// next load.
module bpmc_down_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/bpmc_pulse_timer.sv
// Programmable pulse-timing sequencer for the bipolar pulse path. Issues
// one-cycle front and rear strobes for the downstream pulse combiner.
// Ports:
//   Clock, Reset         - rising-edge clock, synchronous active-high reset
//   Start, Stop          - level-sampled run start / abort
//   Delay, Width, Period - timing fields in cycles, latched at start
//   Burst                - number of pulses, 0 = continuous
//   Front_out, Rear_out  - one-cycle edge strobes
//   Busy                 - high while a run is active
//   Done                 - one-cycle pulse at normal burst completion
//   Err                  - one-cycle pulse when Start sees a bad config
//   state_dbg            - current FSM state (bpmc_state_t encoding)
// Handshake: Start is accepted only when sampled high in IDLE with Stop low;
// there is no ready signal, the requester watches Busy to know when a new
// Start will be taken (first cycle Busy is low).
module bpmc_pulse_timer
  import bpmc_pkg::*;
#(
  parameter int CNT_W   = BPMC_CNT_W,
  parameter int BURST_W = BPMC_BURST_W
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic               Stop,
  input  logic [CNT_W-1:0]   Delay,
  input  logic [CNT_W-1:0]   Width,
  input  logic [CNT_W-1:0]   Period,
  input  logic [BURST_W-1:0] Burst,
  output logic               Front_out,
  output logic               Rear_out,
  output logic               Busy,
  output logic               Done,
  output logic               Err,
  output logic [2:0]         state_dbg
);

  localparam logic [CNT_W-1:0]   ONE  = CNT_W'(1);
  localparam logic [BURST_W-1:0] BONE = BURST_W'(1);

  bpmc_state_t state, next_state;

  logic [CNT_W-1:0]   width_q, period_q;
  logic [BURST_W-1:0] burst_q, pulse_cnt;
  logic               abort_q, abort_next;
  logic               accept, err_next;
  logic               ph_load, ph_tc;
  logic [CNT_W-1:0]   ph_load_value;

  // One counter times every phase. It is loaded with (length - 1) on entry
  // to a phase so tc marks the last cycle of that phase. Delay is consumed
  // directly by this load, so it needs no shadow register of its own.
  bpmc_down_counter #(.W(CNT_W)) u_phase_cnt (
    .clk        (Clock),
    .rst        (Reset),
    .load       (ph_load),
    .load_value (ph_load_value),
    .tc         (ph_tc)
  );

  always_comb begin
    next_state    = state;
    ph_load       = 1'b0;
    ph_load_value = '0;
    accept        = 1'b0;
    err_next      = 1'b0;
    abort_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (Start && !Stop) begin
          if (Width == '0 || Period <= Width) begin
            err_next = 1'b1;
          end else begin
            accept  = 1'b1;
            ph_load = 1'b1;
            // Zero delay skips DELAY so the front lands the cycle after Start.
            if (Delay == '0) begin
              next_state    = ST_HIGH;
              ph_load_value = Width - ONE;
            end else begin
              next_state    = ST_DELAY;
              ph_load_value = Delay - ONE;
            end
          end
        end
      end
      ST_DELAY: begin
        if (Stop) begin
          next_state = ST_IDLE;
        end else if (ph_tc) begin
          next_state    = ST_HIGH;
          ph_load       = 1'b1;
          ph_load_value = width_q - ONE;
        end
      end
      ST_HIGH: begin
        // An abort still closes the open pulse: pass through LOW for the
        // rear strobe, then straight to IDLE.
        if (Stop) begin
          next_state = ST_LOW;
          abort_next = 1'b1;
        end else if (ph_tc) begin
          next_state    = ST_LOW;
          ph_load       = 1'b1;
          ph_load_value = period_q - width_q - ONE;
        end
      end
      ST_LOW: begin
        if (abort_q || Stop) begin
          next_state = ST_IDLE;
        end else if (burst_q != '0 && pulse_cnt == burst_q) begin
          next_state = ST_FIN;
        end else if (ph_tc) begin
          next_state    = ST_HIGH;
          ph_load       = 1'b1;
          ph_load_value = width_q - ONE;
        end
      end
      ST_FIN: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Outputs are registered from the state transition, so each strobe is
  // visible in the first cycle of the state it announces.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= ST_IDLE;
      width_q   <= '0;
      period_q  <= '0;
      burst_q   <= '0;
      pulse_cnt <= '0;
      abort_q   <= 1'b0;
      Front_out <= 1'b0;
      Rear_out  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state   <= next_state;
      abort_q <= abort_next;
      if (accept) begin
        width_q   <= Width;
        period_q  <= Period;
        burst_q   <= Burst;
        pulse_cnt <= '0;
      end else if (state == ST_HIGH && next_state == ST_LOW) begin
        // Wraps freely in continuous mode; only compared when Burst != 0.
        pulse_cnt <= pulse_cnt + BONE;
      end
      Front_out <= (next_state == ST_HIGH) && (state != ST_HIGH);
      Rear_out  <= (next_state == ST_LOW) && (state != ST_LOW);
      Busy      <= (next_state != ST_IDLE);
      Done      <= (next_state == ST_FIN);
      Err       <= err_next;
    end
  end

  assign state_dbg = state;

endmodule
